// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 16-bit execute unit.
// Single-cycle ALU operations complete one edge after capture; shifts
// step one bit per cycle. Carry, zero and negative flags are kept here
// for ADDC/SUBC/CMP and the branch logic. All outputs are registered.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SLA  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_ADDC = 4'hA;
    localparam logic [3:0] OP_SUBC = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_LDIH = 4'hD;
    localparam logic [3:0] OP_BRT  = 4'hE;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic [3:0]       cnt_q;
    logic             sh_c_q;
    logic             sh_nz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_c_q;
    logic             flag_z_q;
    logic             flag_n_q;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] ex_val_d;
    logic             ex_c_d;
    logic             wr_res_d;
    logic             wr_zn_d;
    logic [WIDTH:0]   step_d;

    // One shift step: returns {bit shifted out, shifted word}.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] w);
        logic [WIDTH:0]          r;
        logic signed [WIDTH-1:0] sw;
        sw = w;
        case (op)
            OP_SLL:  r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {w[0], 1'b0, w[WIDTH-1:1]};
            // Sign bit stays put; the bit below it is the one lost.
            OP_SLA:  r = {w[WIDTH-2], w[WIDTH-1], w[WIDTH-3:0], 1'b0};
            OP_SRA:  r = {w[0], WIDTH'(sw >>> 1)};
            default: r = {1'b0, w};
        endcase
        return r;
    endfunction

    // Single-cycle ALU datapath on the captured operands.
    always_comb begin
        sum_d    = '0;
        ex_val_d = '0;
        ex_c_d   = flag_c_q;
        wr_res_d = 1'b0;
        wr_zn_d  = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum_d    = {1'b0, a_q} + {1'b0, b_q};
                ex_val_d = sum_d[WIDTH-1:0];
                ex_c_d   = sum_d[WIDTH];
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // Bit WIDTH of the extended difference is the borrow.
                sum_d    = {1'b0, a_q} - {1'b0, b_q};
                ex_val_d = sum_d[WIDTH-1:0];
                ex_c_d   = sum_d[WIDTH];
                wr_res_d = (op_q == OP_SUB);
                wr_zn_d  = 1'b1;
            end
            OP_AND: begin
                ex_val_d = a_q & b_q;
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_OR: begin
                ex_val_d = a_q | b_q;
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_XOR: begin
                ex_val_d = a_q ^ b_q;
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_ADDC: begin
                sum_d    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, flag_c_q};
                ex_val_d = sum_d[WIDTH-1:0];
                ex_c_d   = sum_d[WIDTH];
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_SUBC: begin
                sum_d    = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, flag_c_q};
                ex_val_d = sum_d[WIDTH-1:0];
                ex_c_d   = sum_d[WIDTH];
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_LDIH: begin
                sum_d    = {1'b0, a_q} + {1'b0, b_q[7:0], 8'h00};
                ex_val_d = sum_d[WIDTH-1:0];
                ex_c_d   = sum_d[WIDTH];
                wr_res_d = 1'b1;
                wr_zn_d  = 1'b1;
            end
            OP_BRT: begin
                ex_val_d = a_q + b_q;
                wr_res_d = 1'b1;
            end
            default: begin
                // NOP/HALT/JUMP/IDLE: nothing written.
            end
        endcase
        step_d = shift_step(op_q, work_q);
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sh_c_q   <= 1'b0;
            sh_nz_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= alucontrol;
                        a_q    <= a;
                        b_q    <= b;
                        busy_q <= 1'b1;
                        if (alucontrol >= OP_SLL && alucontrol <= OP_SRA) begin
                            state_q <= S_SHIFT;
                            work_q  <= a;
                            cnt_q   <= b[3:0];
                            sh_nz_q <= (b[3:0] != 4'd0);
                            sh_c_q  <= 1'b0;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (wr_res_d) begin
                        result_q <= ex_val_d;
                    end
                    if (wr_zn_d) begin
                        flag_c_q <= ex_c_d;
                        flag_z_q <= (ex_val_d == '0);
                        flag_n_q <= ex_val_d[WIDTH-1];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_SHIFT: begin
                    if (cnt_q != 4'd0) begin
                        work_q <= step_d[WIDTH-1:0];
                        sh_c_q <= step_d[WIDTH];
                        cnt_q  <= cnt_q - 4'd1;
                    end else begin
                        result_q <= work_q;
                        flag_z_q <= (work_q == '0);
                        flag_n_q <= work_q[WIDTH-1];
                        if (sh_nz_q) begin
                            flag_c_q <= sh_c_q;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;
    assign flag_n = flag_n_q;

endmodule
